clock_set_ctrl: RTL
===================

# clock_set_ctrl

Run/set controller for the seconds-minutes-hours time-of-day counter chain.
- In RUN mode it prescales `clk` into a one-second enable and advances the chain.
- In the three SET modes it freezes the time and lets a user increment or decrement one selected field, with a blink strobe for the display.
- It sits between debounced push-button pulses and the seven-segment/display driver.

## Interface
Parameters:
- `CLK_DIV`, default 10 — `clk` cycles per second; must be even and ≥ 2.

Ports:
- `clk`  in  1 — single clock, all logic on rising edge.
- `rst_n`  in  1 — reset, synchronous, active-low.
- `mode`  in  1 — one-cycle pulse; advances the mode.
- `inc`  in  1 — one-cycle pulse; adds 1 to the selected field.
- `dec`  in  1 — one-cycle pulse; subtracts 1 from the selected field.
- `sec`  out  6 — seconds, 0..59.
- `min`  out  6 — minutes, 0..59.
- `hr`  out  5 — hours, 0..23.
- `field`  out  2 — current mode: 0 RUN, 1 SET_HR, 2 SET_MIN, 3 SET_SEC.
- `blink`  out  1 — display enable for the selected field.
- `tick_1s`  out  1 — one-second enable, high for one cycle.

## Operation
- Reset (`rst_n`=0 at an edge), from any state including mid-SET:
  - state RUN; `sec`/`min`/`hr` = 0; prescaler = 0; `blink` = 1.
  - `tick_1s` = 0 while in reset.
- FSM transitions on `mode` = 1: RUN → SET_HR → SET_MIN → SET_SEC → RUN. `field` always equals the state encoding.
- RUN:
  - Prescaler counts 0..CLK_DIV-1 and wraps.
  - `tick_1s` = (state == RUN) & (prescaler == CLK_DIV-1). This is combinational from registers.
  - On a tick edge, `sec` increments. 59 → 0 carries into `min`; `min` 59 → 0 carries into `hr`; `hr` 23 → 0.
  - 23:59:59 → 00:00:00 in a single edge.
  - `inc`/`dec` are ignored.
  - `blink` = 1 constant.
- SET_x:
  - Time does not advance and `tick_1s` = 0.
  - The prescaler keeps running; it drives blink only.
  - `inc`: selected field +1 modulo M (60/60/24). No carry into any other field.
  - `dec`: selected field -1 modulo M; 0 wraps to M-1 (`hr` 0 → 23, `min`/`sec` 0 → 59). No borrow.
- Simultaneous events:
  - `inc` & `dec` together: no change.
  - `mode` together with `inc`/`dec`: mode wins; the field is unchanged.
  - SET_SEC → RUN with `inc`: the transition happens and `sec` is unchanged.
- Entering any state via `mode`:
  - Prescaler cleared to 0.
  - `blink` forced to 1.
  - Consequently, the first tick after returning to RUN occurs exactly CLK_DIV cycles after the `mode` edge.
- Blink in SET states: `blink` toggles at the edge where the prescaler equals CLK_DIV/2-1 and at the edge where it equals CLK_DIV-1. This gives a 1 s period with 50 % duty.

## Timing
- All outputs except `tick_1s` are registered.
- `field` changes on the edge sampling `mode` = 1. Visible one cycle after the pulse.
- An `inc`/`dec` effect is visible one cycle after the pulse.
- `sec` updates on the same edge at which `tick_1s` is high.
- In steady RUN, `tick_1s` is high once every CLK_DIV cycles. The first tick after reset is on cycle CLK_DIV (prescaler value CLK_DIV-1).
- Back-to-back pulses (one per cycle) are each honoured. There is no rate limit and no handshake.

## Structure
- Package `clock_ctrl_pkg`:
  - enum `field_e` {RUN, SET_HR, SET_MIN, SET_SEC}, 2 bits.
  - constants `SEC_M`=60, `MIN_M`=60, `HR_M`=24.
- Sub-module `wrap_counter #(M)`: a mod-M up/down counter.
  - Inputs: `clk`, `rst_n`, `up`, `dn`.
  - Outputs: `cnt` ($clog2(M) bits) and `co` (= `up` & `cnt` == M-1).
  - `up` & `dn` together means hold.
  - Instantiated three times (sec, min, hr) plus once as the prescaler, `wrap_counter #(CLK_DIV)`.
  - For the prescaler, `up` is tied to 1 and a synchronous clear is supplied by the FSM on mode change.
- Top: FSM, blink toggle, and the muxing of `tick`/`co`/`inc`/`dec` onto each counter's `up`/`dn`.

## Test plan
Each scenario uses CLK_DIV = 10.
- Reset: hold `rst_n`=0 for 3 cycles, release → 00:00:00, `field`=0, `blink`=1, then `tick_1s` pulses on cycles 10, 20, 30 with `sec` = 1, 2, 3.
- Rollover: set via SET modes to 23:59:59, return to RUN → exactly 10 cycles later 00:00:00 on a single edge.
- Set wrap: in SET_HR at hr=0, `dec` → hr=23. In SET_MIN at 59, `inc` → 0, with hr unchanged.
- Simultaneous: in SET_MIN pulse `mode`+`inc` in one cycle → `field`=3, `min` unchanged. Pulse `inc`+`dec` → no change.
- Blink: in SET_SEC for 40 cycles → `blink` toggles every 5 cycles, starting at 1. Time frozen and `tick_1s` = 0 throughout.
- Reset mid-operation: drive `rst_n`=0 for 1 cycle while in SET_MIN with time 12:34:56 → next cycle RUN, 00:00:00, `blink`=1.

Source files
------------

// File: rtl/clock_ctrl_pkg.sv
// clock_ctrl_pkg: shared mode encoding and field moduli for the time-of-day controller
package clock_ctrl_pkg;
  typedef enum logic [1:0] {RUN, SET_HR, SET_MIN, SET_SEC} field_e;
  localparam int SEC_M = 60;
  localparam int MIN_M = 60;
  localparam int HR_M = 24;
endpackage

// File: rtl/wrap_counter.sv
// wrap_counter: mod-M up/down counter with sync clear; up and dn together hold
module wrap_counter #(
  parameter int M = 60
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 up,
  input  logic                 dn,
  output logic [$clog2(M)-1:0] cnt,
  output logic                 co
);
  localparam int W = $clog2(M);
  localparam logic [W-1:0] MAX = W'(M - 1);
  assign co = up & (cnt == MAX);
  always_ff @(posedge clk)
    if (!rst_n || clr) cnt <= '0;
    else if (up && !dn) cnt <= (cnt == MAX) ? '0 : cnt + 1'b1;
    else if (dn && !up) cnt <= (cnt == '0) ? MAX : cnt - 1'b1;
endmodule

// File: rtl/clock_set_ctrl.sv
// clock_set_ctrl: run/set controller for the sec-min-hr counter chain with blink strobe
module clock_set_ctrl
  import clock_ctrl_pkg::*;
#(
  parameter int CLK_DIV = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       mode,
  input  logic       inc,
  input  logic       dec,
  output logic [5:0] sec,
  output logic [5:0] min,
  output logic [4:0] hr,
  output logic [1:0] field,
  output logic       blink,
  output logic       tick_1s
);
  localparam int PW = $clog2(CLK_DIV);
  field_e st;
  logic [PW-1:0] pre;
  logic pre_co, run, sec_co, min_co;
  logic sec_up, sec_dn, min_up, min_dn, hr_up, hr_dn;
  assign run = (st == RUN);
  assign field = st;
  assign tick_1s = run & pre_co;
  // mode takes priority over inc/dec, so edits are gated off on a mode pulse
  assign sec_up = run ? tick_1s : (st == SET_SEC) & ~mode & inc;
  assign sec_dn = ~run & (st == SET_SEC) & ~mode & dec;
  assign min_up = run ? sec_co : (st == SET_MIN) & ~mode & inc;
  assign min_dn = ~run & (st == SET_MIN) & ~mode & dec;
  assign hr_up = run ? min_co : (st == SET_HR) & ~mode & inc;
  assign hr_dn = ~run & (st == SET_HR) & ~mode & dec;
  wrap_counter #(.M(CLK_DIV)) u_pre (
    .clk(clk), .rst_n(rst_n), .clr(mode), .up(1'b1), .dn(1'b0), .cnt(pre), .co(pre_co)
  );
  wrap_counter #(.M(SEC_M)) u_sec (
    .clk(clk), .rst_n(rst_n), .clr(1'b0), .up(sec_up), .dn(sec_dn), .cnt(sec), .co(sec_co)
  );
  wrap_counter #(.M(MIN_M)) u_min (
    .clk(clk), .rst_n(rst_n), .clr(1'b0), .up(min_up), .dn(min_dn), .cnt(min), .co(min_co)
  );
  wrap_counter #(.M(HR_M)) u_hr (
    .clk(clk), .rst_n(rst_n), .clr(1'b0), .up(hr_up), .dn(hr_dn), .cnt(hr), .co()
  );
  always_ff @(posedge clk)
    if (!rst_n) begin
      st <= RUN;
      blink <= 1'b1;
    end else if (mode) begin
      st <= field_e'(st + 2'd1);
      blink <= 1'b1;
    end else if (run) blink <= 1'b1;
    else if (pre == PW'(CLK_DIV / 2 - 1) || pre_co) blink <= ~blink;
endmodule
